hub75_scan_controller: RTL



---
 rtl/hub75_scan_controller_if.sv | 26 ++
 rtl/hub75_scan_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/hub75_scan_controller_if.sv
// Framebuffer port-B read bus plus HUB75 panel pins driven by the scan controller.
// The master side is the scan controller; the slave side is the RAM and panel.
interface hub75_scan_controller_if #(
    parameter int ADDR_B_BITS = 10,
    parameter int DATA_B_BITS = 64,
    parameter int NSUB        = 2,
    parameter int ROW_BITS    = 4
);
    logic [ADDR_B_BITS-1:0] rd_addr_b;
    logic [DATA_B_BITS-1:0] rd_data_b;
    logic [3*NSUB-1:0]      rgb;
    logic                   panel_clk;
    logic                   panel_latch;
    logic                   panel_oe_n;
    logic [ROW_BITS-1:0]    row_addr;

    modport master (
        output rd_addr_b, rgb, panel_clk, panel_latch, panel_oe_n, row_addr,
        input  rd_data_b
    );

    modport slave (
        input  rd_addr_b, rgb, panel_clk, panel_latch, panel_oe_n, row_addr,
        output rd_data_b
    );
endinterface

// File: rtl/hub75_scan_controller.sv
// HUB75 scan-out: walks scan rows and BCM bit-planes, shifting one column per two
// clocks from framebuffer port B, then latching and un-blanking for a plane-weighted time.
//
// state   | meaning
// IDLE    | stopped, panel blanked, row/plane held for resume
// SHIFT   | fetch columns and clock them into the panel
// LATCH   | one-cycle latch strobe, row lines updated
// DISPLAY | OE active for BASE_DISPLAY_CYCLES << plane cycles
// NEXT    | advance plane/row, sample enable
module hub75_scan_controller #(
    parameter int PIXEL_WIDTH         = 64,
    parameter int PIXEL_HEIGHT        = 32,
    parameter int PIXEL_HALFHEIGHT    = 16,
    parameter int BYTES_PER_PIXEL     = 3,
    parameter int PLANES              = 8,
    parameter int BASE_DISPLAY_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    hub75_scan_controller_if.master  bus,
    output logic                     frame_done,
    output logic                     busy
);
    localparam int NSUB         = PIXEL_HEIGHT / PIXEL_HALFHEIGHT;
    localparam int ROW_BITS     = $clog2(PIXEL_HALFHEIGHT);
    localparam int COL_BITS     = $clog2(PIXEL_WIDTH);
    localparam int DATA_B_BITS  = ((2 ** $clog2(BYTES_PER_PIXEL)) << $clog2(NSUB)) << 3;
    localparam int BITS_PER_SUB = DATA_B_BITS >> $clog2(NSUB);
    localparam int PLANE_BITS   = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int STEP_BITS    = COL_BITS + 2;
    localparam int DISP_BITS    = 8 + PLANES;

    localparam logic [STEP_BITS-1:0]  STEP_LAST  = STEP_BITS'(2 * PIXEL_WIDTH + 1);
    localparam logic [STEP_BITS-1:0]  STEP_LOADS = STEP_BITS'(2 * PIXEL_WIDTH);
    localparam logic [STEP_BITS-1:0]  STEP_ADDRS = STEP_BITS'(2 * PIXEL_WIDTH - 1);
    localparam logic [ROW_BITS-1:0]   LAST_ROW   = ROW_BITS'(PIXEL_HALFHEIGHT - 1);
    localparam logic [PLANE_BITS-1:0] LAST_PLANE = PLANE_BITS'(PLANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY,
        ST_NEXT
    } state_t;

    state_t                state;
    logic [ROW_BITS-1:0]   row;
    logic [PLANE_BITS-1:0] plane;
    logic [STEP_BITS-1:0]  step;
    logic [DISP_BITS-1:0]  disp_cnt;
    logic [ROW_BITS-1:0]   next_row;
    logic [3*NSUB-1:0]     rgb_plane;

    always_comb begin
        next_row = (row == LAST_ROW) ? '0 : row + ROW_BITS'(1);
    end

    // Pick the current plane's bit out of the R/G/B byte lanes of each subpanel.
    always_comb begin
        rgb_plane = '0;
        for (int s = 0; s < NSUB; s++) begin
            for (int k = 0; k < 3; k++) begin
                rgb_plane[3*s+k] = bus.rd_data_b[s*BITS_PER_SUB + k*8 + int'(plane)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            row             <= '0;
            plane           <= '0;
            step            <= '0;
            disp_cnt        <= '0;
            bus.rd_addr_b   <= '0;
            bus.rgb         <= '0;
            bus.panel_clk   <= 1'b0;
            bus.panel_latch <= 1'b0;
            bus.panel_oe_n  <= 1'b1;
            bus.row_addr    <= '0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state         <= ST_SHIFT;
                        busy          <= 1'b1;
                        step          <= '0;
                        bus.rd_addr_b <= {row, COL_BITS'(0)};
                    end
                end
                ST_SHIFT: begin
                    step          <= step + STEP_BITS'(1);
                    // Rising edge one cycle after data settles for each column.
                    bus.panel_clk <= !step[0] && (step != '0);
                    if (step[0] && step < STEP_LOADS) begin
                        bus.rgb <= rgb_plane;
                        if (step < STEP_ADDRS) begin
                            bus.rd_addr_b <= {row, step[COL_BITS:1] + COL_BITS'(1)};
                        end
                    end
                    if (step == STEP_LAST) begin
                        state           <= ST_LATCH;
                        bus.panel_latch <= 1'b1;
                        bus.row_addr    <= row;
                    end
                end
                ST_LATCH: begin
                    state           <= ST_DISPLAY;
                    bus.panel_latch <= 1'b0;
                    bus.panel_oe_n  <= 1'b0;
                    disp_cnt        <= (DISP_BITS'(BASE_DISPLAY_CYCLES) << plane) - DISP_BITS'(1);
                end
                ST_DISPLAY: begin
                    if (disp_cnt == '0) begin
                        state          <= ST_NEXT;
                        bus.panel_oe_n <= 1'b1;
                        frame_done     <= (plane == LAST_PLANE) && (row == LAST_ROW);
                    end else begin
                        disp_cnt <= disp_cnt - DISP_BITS'(1);
                    end
                end
                ST_NEXT: begin
                    if (plane == LAST_PLANE) begin
                        plane <= '0;
                        row   <= next_row;
                    end else begin
                        plane <= plane + PLANE_BITS'(1);
                    end
                    if (enable) begin
                        state         <= ST_SHIFT;
                        step          <= '0;
                        bus.rd_addr_b <= {(plane == LAST_PLANE) ? next_row : row, COL_BITS'(0)};
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
